shdw_dump_chan: RTL and testbench
=================================

// Module: shdw_dump_chan
// PURPOSE
//  One shadow-state capture/dump channel, directly upstream of the shadow-to-MicroBlaze FSL bridge.
//  - While the core runs (c_en=1), it continuously snapshots a wide live shadow-state vector.
//  - When the core is frozen (c_en=0), it serialises the frozen snapshot as 32-bit words.
//  - Words are pulled one per dump_en strobe and flagged with sh_out_vld / sh_out_done.
//  - The bridge instantiates up to 32 channels and maps channel i to bit i of its dump_en/sh_out_vld/sh_out_done buses.
// PARAMETERS
//  STATE_W   256  width of shadow state vector, >=1; localparam WORDS = ceil(STATE_W/32)
// PORTS
//  clk          in   1        single clock, all logic rising-edge
//  rst          in   1        asynchronous active-low reset
//  sh_rst       in   1        synchronous clear of snapshot/dump state, from bridge
//  c_en         in   1        core clock enable; 1=track live state, 0=frozen
//  sh_state     in   STATE_W  live shadow state from injected logic
//  dump_en      in   1        pull strobe: one word requested per cycle high
//  sh_out       out  32       dump word
//  sh_out_vld   out  1        sh_out valid, one-cycle pulse per word
//  sh_out_done  out  1        last word delivered; level, held until cleared
// BEHAVIOUR
//  Reset (rst=0):
//  - sh_out=0, sh_out_vld=0, sh_out_done=0, snapshot=0, ptr=0.
//  - FSM=TRACK.
//  FSM TRACK:
//  - Each cycle with c_en=1: snap <= sh_state.
//  - dump_en is ignored.
//  - c_en=0 -> FROZEN. Snap keeps the last value sampled while c_en=1.
//  FSM FROZEN:
//  - ptr=0; waits for dump_en.
//  - dump_en=1 -> next cycle: sh_out=word[0], vld=1, ptr=1.
//  - Then go to DUMP, or to DONE if total words = 1.
//  FSM DUMP:
//  - Each cycle with dump_en=1 -> next cycle: sh_out=word[ptr], vld=1, ptr++.
//  - dump_en=0: no vld; sh_out holds the last word.
//  - On the last word: sh_out_done rises in the same cycle as its vld, then FSM -> DONE.
//  FSM DONE:
//  - sh_out_done held at 1; dump_en ignored (no vld).
//  - c_en=1 -> TRACK, done cleared next cycle.
//  Word mapping:
//  - word[k] = snap[32k+31:32k], word 0 first.
//  - The last word is zero-padded above bit STATE_W-1.
//  Latency and throughput:
//  - Fixed 1 cycle from sampled dump_en to vld.
//  - Back-to-back strobes give 1 word/cycle.
//  Abort:
//  - c_en rising in FROZEN or DUMP -> TRACK immediately.
//  - ptr=0, no further vld, done stays 0.
//  - A later freeze restarts at word 0.
//  sh_rst (priority over all other events):
//  - snap=0, ptr=0, vld=0, done=0.
//  - FSM goes to TRACK if c_en=1, else FROZEN.
//  - A same-cycle dump_en is dropped.
//  Other invariants:
//  - sh_state changes while frozen never affect the dump.
//  - vld is never asserted in TRACK or DONE.
// CONFIGURATION
//  SHDW_DUMP_CSUM_EN defined:
//  - One extra word is appended after word[WORDS-1]: the XOR of all WORDS padded words.
//  - Total words = WORDS+1; sh_out_done coincides with the checksum word's vld.
//  SHDW_DUMP_CSUM_EN undefined:
//  - Exactly WORDS words; no checksum logic.
// TESTING
//  All scenarios use STATE_W=72, csum off unless noted.
//  1 Reset: hold rst=0 with c_en=1, dump_en=1 -> sh_out=0, vld=0, done=0.
//    After release with c_en=1 -> no vld for 20 cycles.
//  2 Basic dump: sh_state=72'hAB_12345678_9ABCDEF0, c_en 1->0, dump_en high 4 cycles.
//    -> vld on 3 consecutive cycles, sh_out=9ABCDEF0, 12345678, 000000AB.
//    -> done=1 with the third vld; no 4th vld.
//  3 Freeze isolation: after freeze set sh_state=0, pulse dump_en every 3rd cycle.
//    -> same 3 words as scenario 2, each 1 cycle after its strobe.
//  4 Abort: raise c_en after the first vld -> no more vld, done=0.
//    Refreeze and strobe -> dump restarts at 9ABCDEF0.
//  5 sh_rst: assert sh_rst during DUMP with c_en=0 -> vld/done=0.
//    Next 3 strobes -> words 00000000 x3, done with the third.
//  6 SHDW_DUMP_CSUM_EN: scenario 2 -> 4 vld words, the 4th = 88888823, done with the 4th.

Source files
------------

// File: rtl/shdw_dump_chan_if.sv
// Bridge-facing dump bus of one shadow-state channel.
// The bridge (master) drives the clear and pull strobes; the channel
// (slave) returns the dump word and its valid/done flags.
interface shdw_dump_chan_if;
  logic        sh_rst;
  logic        dump_en;
  logic [31:0] sh_out;
  logic        sh_out_vld;
  logic        sh_out_done;

  modport master (
    output sh_rst,
    output dump_en,
    input  sh_out,
    input  sh_out_vld,
    input  sh_out_done
  );

  modport slave (
    input  sh_rst,
    input  dump_en,
    output sh_out,
    output sh_out_vld,
    output sh_out_done
  );
endinterface

// File: rtl/shdw_dump_chan.sv
// Shadow-state capture/dump channel.
// Tracks the live shadow vector while the core runs, freezes it when the
// core stops, and serialises the snapshot as 32-bit words, one per
// dump_en strobe with one cycle of latency.
// Optional feature: define SHDW_DUMP_CSUM_EN to append an XOR checksum
// word after the last data word.
module shdw_dump_chan #(
  parameter int STATE_W = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               c_en,
  input  logic [STATE_W-1:0] sh_state,
  shdw_dump_chan_if.slave    dmp
);

  localparam int WORDS = (STATE_W + 31) / 32;
`ifdef SHDW_DUMP_CSUM_EN
  localparam int TOTAL_WORDS = WORDS + 1;
`else
  localparam int TOTAL_WORDS = WORDS;
`endif
  // ptr must be able to count one past the last word.
  localparam int PTR_W = $clog2(TOTAL_WORDS + 1);

  localparam logic [1:0] S_TRACK  = 2'd0;
  localparam logic [1:0] S_FROZEN = 2'd1;
  localparam logic [1:0] S_DUMP   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [STATE_W-1:0] snap_q, snap_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [31:0]        sh_out_q, sh_out_d;
  logic               vld_q, vld_d;
  logic               done_q, done_d;

  logic [WORDS*32-1:0] snap_pad;
  logic [31:0]         words [TOTAL_WORDS];
  logic [31:0]         word_sel;
  logic                last_word;

  // Split the zero-padded snapshot into words, plus the checksum if enabled.
  always_comb begin
    snap_pad                = '0;
    snap_pad[STATE_W-1:0]   = snap_q;
    for (int k = 0; k < WORDS; k++) begin
      words[k] = snap_pad[32*k +: 32];
    end
`ifdef SHDW_DUMP_CSUM_EN
    words[WORDS] = '0;
    for (int k = 0; k < WORDS; k++) begin
      words[WORDS] = words[WORDS] ^ snap_pad[32*k +: 32];
    end
`endif
  end

  // Select the word addressed by ptr and flag the final one.
  always_comb begin
    word_sel = '0;
    for (int k = 0; k < TOTAL_WORDS; k++) begin
      if (ptr_q == PTR_W'(k)) word_sel = words[k];
    end
    last_word = (ptr_q == PTR_W'(TOTAL_WORDS - 1));
  end

  // Next-state logic: sh_rst first, then the TRACK/FROZEN/DUMP/DONE FSM.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    state_d  = state_q;
    snap_d   = c_en ? sh_state : snap_q;
    ptr_d    = ptr_q;
    sh_out_d = sh_out_q;
    vld_d    = 1'b0;
    done_d   = done_q;

    if (dmp.sh_rst) begin
      snap_d  = '0;
      ptr_d   = '0;
      done_d  = 1'b0;
      state_d = c_en ? S_TRACK : S_FROZEN;
    end else begin
      case (state_q)
        S_TRACK: begin
          if (!c_en) begin
            state_d = S_FROZEN;
            ptr_d   = '0;
          end
        end
        // FROZEN is DUMP with ptr known to be zero, so they share one body.
        S_FROZEN, S_DUMP: begin
          if (c_en) begin
            state_d = S_TRACK;
            ptr_d   = '0;
          end else if (dmp.dump_en) begin
            sh_out_d = word_sel;
            vld_d    = 1'b1;
            ptr_d    = ptr_q + PTR_W'(1);
            if (last_word) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_DUMP;
            end
          end
        end
        S_DONE: begin
          if (c_en) begin
            state_d = S_TRACK;
            ptr_d   = '0;
            done_d  = 1'b0;
          end
        end
        default: state_d = S_TRACK;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_TRACK;
      snap_q   <= '0;
      ptr_q    <= '0;
      sh_out_q <= '0;
      vld_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
      state_q  <= state_d;
      snap_q   <= snap_d;
      ptr_q    <= ptr_d;
      sh_out_q <= sh_out_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
    end
  end

  assign dmp.sh_out      = sh_out_q;
  assign dmp.sh_out_vld  = vld_q;
  assign dmp.sh_out_done = done_q;

endmodule

// File: tb/tb_shdw_dump_chan.sv
// Directed testbench for shdw_dump_chan with STATE_W=72 (three data words).
// Define SHDW_DUMP_CSUM_EN for both bench and RTL to cover the checksum word.
module tb_shdw_dump_chan;

  localparam int STATE_W = 72;
`ifdef SHDW_DUMP_CSUM_EN
  localparam int TOTAL = 4;
`else
  localparam int TOTAL = 3;
`endif
  localparam logic [71:0] PATTERN = 72'hAB_12345678_9ABCDEF0;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               c_en;
  logic [STATE_W-1:0] sh_state;

  shdw_dump_chan_if dmp_if ();

  shdw_dump_chan #(.STATE_W(STATE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .c_en     (c_en),
    .sh_state (sh_state),
    .dmp      (dmp_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Hand-computed words of PATTERN; the last is the XOR of the first three.
  logic [31:0] exp_words [4] = '{32'h9ABCDEF0, 32'h12345678, 32'h000000AB, 32'h88888823};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [31:0] word,
                           input logic done);
    check({tag, "_vld"},  32'(dmp_if.sh_out_vld),  32'(vld));
    check({tag, "_word"}, dmp_if.sh_out,           word);
    check({tag, "_done"}, 32'(dmp_if.sh_out_done), 32'(done));
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int vld_seen;

  initial begin
    // Reset held with active inputs.
    c_en           = 1'b1;
    sh_state       = PATTERN;
    dmp_if.dump_en = 1'b1;
    dmp_if.sh_rst  = 1'b0;
    repeat (3) tick();
    check_out("rst", 1'b0, 32'h0, 1'b0);

    // Tracking after release: dump_en ignored.
    rst      = 1'b1;
    vld_seen = 0;
    repeat (20) begin
      tick();
      if (dmp_if.sh_out_vld) vld_seen++;
    end
    check("track_no_vld", 32'(vld_seen), 32'd0);
    dmp_if.dump_en = 1'b0;

    // Basic dump with back-to-back strobes.
    sh_state = PATTERN;
    c_en = 1'b1; tick();
    c_en = 1'b0; tick();
    dmp_if.dump_en = 1'b1;
    for (int i = 0; i < TOTAL; i++) begin
      tick();
      check_out($sformatf("s2_w%0d", i), 1'b1, exp_words[i], i == TOTAL - 1);
    end
    tick();
    check_out("s2_extra", 1'b0, exp_words[TOTAL-1], 1'b1);
    dmp_if.dump_en = 1'b0;

    // Freeze isolation with sparse strobes.
    c_en = 1'b1; tick();
    check_out("s3_track", 1'b0, exp_words[TOTAL-1], 1'b0);
    c_en = 1'b0; tick();
    sh_state = '0;
    for (int i = 0; i < TOTAL; i++) begin
      dmp_if.dump_en = 1'b1; tick();
      check_out($sformatf("s3_w%0d", i), 1'b1, exp_words[i], i == TOTAL - 1);
      dmp_if.dump_en = 1'b0; tick();
      check_out($sformatf("s3_gap%0d", i), 1'b0, exp_words[i], i == TOTAL - 1);
      tick();
    end

    // Abort after the first word, then restart from word 0.
    sh_state = PATTERN;
    c_en = 1'b1; tick();
    c_en = 1'b0; tick();
    dmp_if.dump_en = 1'b1; tick();
    check_out("s4_w0", 1'b1, exp_words[0], 1'b0);
    c_en = 1'b1; tick();
    check_out("s4_abort", 1'b0, exp_words[0], 1'b0);
    vld_seen = 0;
    repeat (3) begin
      tick();
      if (dmp_if.sh_out_vld) vld_seen++;
    end
    check("s4_abort_no_vld", 32'(vld_seen), 32'd0);
    check("s4_abort_done", 32'(dmp_if.sh_out_done), 32'd0);
    c_en = 1'b0; tick();
    check_out("s4_refreeze", 1'b0, exp_words[0], 1'b0);
    tick();
    check_out("s4_restart_w0", 1'b1, exp_words[0], 1'b0);
    tick();
    check_out("s4_restart_w1", 1'b1, exp_words[1], 1'b0);

    // sh_rst mid-dump clears the snapshot and drops the same-cycle strobe.
    dmp_if.sh_rst = 1'b1; tick();
    check("s5_rst_vld",  32'(dmp_if.sh_out_vld),  32'd0);
    check("s5_rst_done", 32'(dmp_if.sh_out_done), 32'd0);
    dmp_if.sh_rst = 1'b0;
    for (int i = 0; i < TOTAL; i++) begin
      tick();
      check_out($sformatf("s5_w%0d", i), 1'b1, 32'h0, i == TOTAL - 1);
    end
    dmp_if.dump_en = 1'b0; tick();
    check_out("s5_after", 1'b0, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
